lmg_move_unpacker: RTL and testbench
====================================

// Module: lmg_move_unpacker
// PURPOSE
//  Downstream of LMG. Drains LMG's 160-bit move FIFO and serialises each word's eight 19-bit move
//  slots into a one-move-per-transfer valid/ready stream for the search/eval stage. Drops null
//  (all-zero) slots, counts emitted moves, and flags completion once LMG is done and the FIFO is drained.
// PARAMETERS
//  MV_W     19   width of one move slot
//  NSLOT    8    move slots per FIFO word
//  CNT_W    9    width of mv_count (saturating)
// PORTS
//  clk        in   1    system clock
//  reset      in   1    synchronous, active-high reset
//  lmg_done   in   1    LMG done; high only after its final FIFO write is visible on fifo_empty
//  fifo_out   in   160  LMG FIFO read data; slot1=[151:133] ... slot8=[18:0]; [159:152] ignored
//  fifo_empty in   1    LMG FIFO empty
//  rden       out  1    FIFO read enable; one-cycle pulse per word
//  mv_data    out  19   current move (opaque to this block)
//  mv_valid   out  1    mv_data valid
//  mv_ready   in   1    consumer accepts mv_data when mv_valid&mv_ready at posedge
//  mv_count   out  9    number of moves accepted since reset; saturates at 511
//  all_done   out  1    sticky: every LMG move emitted and accepted
// BEHAVIOUR
//  Reset: all outputs 0 (rden, mv_data, mv_valid, mv_count, all_done); state=FETCH; slot idx=0;
//   done_seen=0. Reset mid-operation discards the latched word and any pending move, no rden issued.
//  FIFO: non-show-ahead; fifo_out valid the cycle after the rden cycle.
//  done_seen: sticky, set on any cycle lmg_done=1.
//  States:
//   FETCH : if !fifo_empty -> rden=1, go LATCH (read has priority over done).
//           else if done_seen|lmg_done -> go DONE. else stay, rden=0.
//   LATCH : rden=0; register fifo_out[151:0] into word buffer; idx=0; go SCAN.
//   SCAN  : examine slot idx (slot1 first). If slot==0: idx++ (one cycle per skipped slot).
//           If nonzero: drive mv_data=slot, mv_valid=1, go HOLD.
//           After idx 7 is resolved (skipped or accepted) -> FETCH.
//   HOLD  : mv_valid=1, mv_data stable until mv_valid&mv_ready; on accept: mv_count++ (sat 511),
//           mv_valid=0 next cycle, idx++; if idx was 7 -> FETCH else SCAN.
//   DONE  : all_done=1, rden=0, mv_valid=0; stays until reset.
//  Timing: rden at cycle T -> data latched T+1 -> earliest mv_valid T+2 (slot1 nonzero).
//   With mv_ready held 1, each nonzero slot costs 2 cycles (SCAN+HOLD), each null slot 1 cycle.
//  rden never asserted when fifo_empty=1, never in two consecutive cycles, never outside FETCH.
//  mv_valid never drops without acceptance; mv_data constant while mv_valid=1.
//  lmg_done arriving while a word is pending: word fully emitted first, then FETCH rechecks FIFO.
//  mv_count counts accepts only; null slots never counted.
// TESTING
//  1 Empty board: fifo_empty=1, lmg_done=1 two cycles after reset release -> no rden, no mv_valid,
//    all_done=1 within 2 cycles, mv_count=0.
//  2 One word, slot1=19'h00123, slot3=19'h4ABCD, others 0, mv_ready=1 -> rden once, mv_data
//    sequence 00123 then 4ABCD, first mv_valid 2 cycles after rden, mv_count=2, then all_done.
//  3 Two full words (16 distinct nonzero moves) -> 16 moves in slot order, word1 before word2,
//    exactly 2 rden pulses, mv_count=16.
//  4 Backpressure: mv_ready low 5 cycles while mv_valid=1 -> mv_data held stable, no count change,
//    no rden; resumes correctly when mv_ready rises.
//  5 lmg_done asserted mid-word with another word still in FIFO -> both words fully emitted
//    before all_done; all_done never precedes last accept.
//  6 Reset asserted in HOLD -> next cycle mv_valid=0, mv_count=0, all_done=0, rden=0; after release
//    unpacking restarts from the FIFO head.

Source files
------------

// File: rtl/lmg_move_unpacker_if.sv
// Move-stream bus: LMG FIFO read side plus the one-move-per-transfer consumer handshake.
interface lmg_move_unpacker_if #(
    parameter int unsigned MV_W   = 19,
    parameter int unsigned CNT_W  = 9,
    parameter int unsigned FIFO_W = 160
);
    logic              lmg_done;
    logic [FIFO_W-1:0] fifo_out;
    logic              fifo_empty;
    logic              rden;
    logic [MV_W-1:0]   mv_data;
    logic              mv_valid;
    logic              mv_ready;
    logic [CNT_W-1:0]  mv_count;
    logic              all_done;

    modport master (
        input  lmg_done, fifo_out, fifo_empty, mv_ready,
        output rden, mv_data, mv_valid, mv_count, all_done
    );

    modport slave (
        output lmg_done, fifo_out, fifo_empty, mv_ready,
        input  rden, mv_data, mv_valid, mv_count, all_done
    );
endinterface

// File: rtl/lmg_move_unpacker.sv
// Drains LMG's packed move FIFO and emits each nonzero 19-bit slot as one valid/ready transfer,
// counting accepted moves and flagging completion once LMG is done and the FIFO is empty.
module lmg_move_unpacker #(
    parameter int unsigned MV_W  = 19,
    parameter int unsigned NSLOT = 8,
    parameter int unsigned CNT_W = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    lmg_move_unpacker_if.master  bus
);
    localparam int unsigned FIFO_W = 160;
    localparam int unsigned WORD_W = MV_W * NSLOT;
    localparam int unsigned IDX_W  = $clog2(NSLOT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLOT - 1);

    // READ is the rden cycle; LATCH is the cycle the non-show-ahead FIFO presents the word
    typedef enum logic [2:0] {FETCH, READ, LATCH, SCAN, HOLD, DONE} stateT;

    stateT             state;
    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] wordBuf;
    logic              doneSeen;

    logic [MV_W-1:0]   curSlot;
    logic [MV_W-1:0]   headSlot;
    logic [WORD_W-1:0] wordShifted;
    logic              unusedFifoHi;

    // The buffer shifts left as slots resolve, so the current slot is always the top field
    assign curSlot      = wordBuf[WORD_W-1 -: MV_W];
    assign headSlot     = bus.fifo_out[WORD_W-1 -: MV_W];
    assign wordShifted  = {wordBuf[WORD_W-MV_W-1:0], MV_W'(0)};
    assign unusedFifoHi = ^bus.fifo_out[FIFO_W-1:WORD_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= FETCH;
            idx          <= '0;
            wordBuf      <= '0;
            doneSeen     <= 1'b0;
            bus.rden     <= 1'b0;
            bus.mv_data  <= '0;
            bus.mv_valid <= 1'b0;
            bus.mv_count <= '0;
            bus.all_done <= 1'b0;
        end else begin
            bus.rden <= 1'b0;
            if (bus.lmg_done) begin
                doneSeen <= 1'b1;
            end

            case (state)
                FETCH: begin
                    if (!bus.fifo_empty) begin
                        bus.rden <= 1'b1;
                        state    <= READ;
                    end else if (doneSeen || bus.lmg_done) begin
                        bus.all_done <= 1'b1;
                        state        <= DONE;
                    end
                end

                READ: begin
                    state <= LATCH;
                end

                // Slot 1 is resolved straight from the FIFO output while the word is captured
                LATCH: begin
                    idx <= '0;
                    if (headSlot != '0) begin
                        wordBuf      <= bus.fifo_out[WORD_W-1:0];
                        bus.mv_data  <= headSlot;
                        bus.mv_valid <= 1'b1;
                        state        <= HOLD;
                    end else begin
                        wordBuf <= {bus.fifo_out[WORD_W-MV_W-1:0], MV_W'(0)};
                        idx     <= IDX_W'(1);
                        state   <= SCAN;
                    end
                end

                SCAN: begin
                    if (curSlot != '0) begin
                        bus.mv_data  <= curSlot;
                        bus.mv_valid <= 1'b1;
                        state        <= HOLD;
                    end else begin
                        wordBuf <= wordShifted;
                        if (idx == LAST_IDX) begin
                            state <= FETCH;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end

                HOLD: begin
                    if (bus.mv_ready) begin
                        bus.mv_valid <= 1'b0;
                        wordBuf      <= wordShifted;
                        if (bus.mv_count != {CNT_W{1'b1}}) begin
                            bus.mv_count <= bus.mv_count + CNT_W'(1);
                        end
                        if (idx == LAST_IDX) begin
                            state <= FETCH;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= SCAN;
                        end
                    end
                end

                DONE: begin
                    bus.all_done <= 1'b1;
                    bus.mv_valid <= 1'b0;
                end

                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lmg_move_unpacker.sv
// Randomised scoreboard bench for lmg_move_unpacker: a FIFO model feeds packed words, a
// reference model queues the expected nonzero slots, and a monitor checks every accepted move.
module tb_lmg_move_unpacker;
    localparam int unsigned MV_W   = 19;
    localparam int unsigned NSLOT  = 8;
    localparam int unsigned CNT_W  = 9;
    localparam int unsigned FIFO_W = 160;
    localparam int unsigned WORD_W = MV_W * NSLOT;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lmg_move_unpacker_if #(.MV_W(MV_W), .CNT_W(CNT_W), .FIFO_W(FIFO_W)) bus();

    lmg_move_unpacker #(.MV_W(MV_W), .NSLOT(NSLOT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Non-show-ahead FIFO model: data appears the cycle after the rden cycle
    logic [FIFO_W-1:0] fifoMem [0:255];
    int pushCnt = 0;
    int popCnt  = 0;
    assign bus.fifo_empty = (pushCnt == popCnt);
    always @(posedge clk) begin
        if (bus.rden) begin
            bus.fifo_out <= fifoMem[popCnt[7:0]];
            popCnt       <= popCnt + 1;
        end
    end

    // Scoreboard of expected moves, written by stimulus and consumed by the monitor
    logic [MV_W-1:0] expMem [0:2047];
    int expWr = 0, expRd = 0, expStart = 0;
    int checks = 0, errors = 0;
    int rdenCnt = 0, validCnt = 0, modelCnt = 0;
    logic prevValid = 1'b0, prevAcc = 1'b0, prevRden = 1'b0, prevAll = 1'b0;
    logic [MV_W-1:0] prevData = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: slot k of a word sits k fields below the top of bits [151:0]
    task automatic addExp(input logic [FIFO_W-1:0] w);
        for (int k = 0; k < int'(NSLOT); k++) begin
            logic [MV_W-1:0] s;
            s = MV_W'(w >> (MV_W * (NSLOT - 1 - k)));
            if (s != '0) begin
                expMem[expWr[10:0]] = s;
                expWr++;
            end
        end
    endtask

    task automatic pushWord(input logic [FIFO_W-1:0] w, input bit withExp);
        if (withExp) addExp(w);
        fifoMem[pushCnt[7:0]] = w;
        pushCnt++;
    endtask

    function automatic logic [FIFO_W-1:0] makeWord(input int density);
        logic [FIFO_W-1:0] w;
        logic [MV_W-1:0]   s;
        w = FIFO_W'($urandom_range(255));
        for (int k = 0; k < int'(NSLOT); k++) begin
            s = (int'($urandom_range(99)) < density) ? MV_W'($urandom_range(524287, 1)) : '0;
            w = (w << MV_W) | FIFO_W'(s);
        end
        return w;
    endfunction

    task automatic waitValid(input int lim, input string name);
        int n = 0;
        while (!bus.mv_valid && n < lim) begin tick(); n++; end
        chk({name, "_valid_wait"}, 32'(bus.mv_valid), 32'd1);
    endtask

    task automatic waitDrain(input int lim, input int readyPct, input string name);
        int n = 0;
        while (!(expRd == expWr && pushCnt == popCnt && !bus.mv_valid) && n < lim) begin
            bus.mv_ready = (int'($urandom_range(99)) < readyPct);
            tick();
            n++;
        end
        chk({name, "_drain_wait"}, 32'(n < lim), 32'd1);
    endtask

    task automatic waitAllDone(input int lim, input string name);
        int n = 0;
        while (!bus.all_done && n < lim) begin tick(); n++; end
        chk({name, "_all_done"}, 32'(bus.all_done), 32'd1);
    endtask

    task automatic doReset();
        reset        = 1'b1;
        bus.lmg_done = 1'b0;
        bus.mv_ready = 1'b0;
        expStart     = expWr;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on every accept
    task automatic monitorLoop();
        logic acc;
        forever begin
            @(negedge clk);
            if (reset) begin
                expRd     = expStart;
                modelCnt  = 0;
                prevValid = 1'b0;
                prevAcc   = 1'b0;
                prevRden  = 1'b0;
                prevAll   = 1'b0;
            end else begin
                chk("mv_count", 32'(bus.mv_count), 32'(modelCnt));
                if (bus.rden) begin
                    rdenCnt++;
                    chk("rden_when_empty", 32'(bus.fifo_empty), 32'd0);
                    chk("rden_back_to_back", 32'(prevRden), 32'd0);
                end
                if (bus.mv_valid) validCnt++;
                if (prevValid && !prevAcc) begin
                    chk("valid_held", 32'(bus.mv_valid), 32'd1);
                    chk("data_stable", 32'(bus.mv_data), 32'(prevData));
                end
                acc = bus.mv_valid && bus.mv_ready;
                if (acc) begin
                    chk("move_pending", 32'(expRd < expWr), 32'd1);
                    if (expRd < expWr) begin
                        chk("mv_data", 32'(bus.mv_data), 32'(expMem[expRd[10:0]]));
                        expRd++;
                    end
                    modelCnt = (modelCnt == 511) ? 511 : modelCnt + 1;
                end
                if (bus.all_done && !prevAll) begin
                    chk("all_done_before_last", 32'(expWr - expRd), 32'd0);
                    chk("all_done_fifo_empty", 32'(bus.fifo_empty), 32'd1);
                end
                prevValid = bus.mv_valid;
                prevAcc   = acc;
                prevRden  = bus.rden;
                prevAll   = bus.all_done;
                prevData  = bus.mv_data;
            end
        end
    endtask

    initial begin
        logic [FIFO_W-1:0] wa, wb;
        int rb, vb, c0, e0, n, tot;
        bus.lmg_done = 1'b0;
        bus.mv_ready = 1'b0;
        fork
            monitorLoop();
        join_none
        tick();
        tick();
        chk("reset_rden", 32'(bus.rden), 32'd0);
        chk("reset_mv_valid", 32'(bus.mv_valid), 32'd0);
        chk("reset_mv_data", 32'(bus.mv_data), 32'd0);
        chk("reset_mv_count", 32'(bus.mv_count), 32'd0);
        chk("reset_all_done", 32'(bus.all_done), 32'd0);
        reset = 1'b0;

        // Empty board
        rb = rdenCnt; vb = validCnt;
        tick();
        tick();
        bus.lmg_done = 1'b1;
        waitAllDone(2, "t1");
        chk("t1_rden_pulses", 32'(rdenCnt - rb), 32'd0);
        chk("t1_valid_cycles", 32'(validCnt - vb), 32'd0);
        chk("t1_mv_count", 32'(bus.mv_count), 32'd0);
        doReset();

        // One sparse word: slot1 and slot3 only
        wa = '0;
        wa[159:152] = 8'hA5;
        wa[151:133] = 19'h00123;
        wa[113:95]  = 19'h4ABCD;
        rb = rdenCnt;
        bus.mv_ready = 1'b1;
        pushWord(wa, 1'b1);
        n = 0;
        while (!bus.rden && n < 10) begin tick(); n++; end
        chk("t2_rden_seen", 32'(bus.rden), 32'd1);
        n = 0;
        while (!bus.mv_valid && n < 10) begin tick(); n++; end
        chk("t2_first_valid_latency", 32'(n), 32'd2);
        chk("t2_first_move", 32'(bus.mv_data), 32'h00123);
        waitDrain(100, 100, "t2");
        chk("t2_mv_count", 32'(bus.mv_count), 32'd2);
        chk("t2_rden_pulses", 32'(rdenCnt - rb), 32'd1);
        bus.lmg_done = 1'b1;
        waitAllDone(20, "t2");
        doReset();

        // Two full words
        rb = rdenCnt;
        pushWord(makeWord(100), 1'b1);
        pushWord(makeWord(100), 1'b1);
        waitDrain(200, 100, "t3");
        chk("t3_mv_count", 32'(bus.mv_count), 32'd16);
        chk("t3_rden_pulses", 32'(rdenCnt - rb), 32'd2);

        // Backpressure with a second word waiting in the FIFO
        bus.mv_ready = 1'b0;
        c0 = int'(bus.mv_count);
        pushWord(makeWord(100), 1'b1);
        pushWord(makeWord(60), 1'b1);
        waitValid(20, "t4");
        rb = rdenCnt;
        repeat (5) begin
            tick();
            chk("t4_held_valid", 32'(bus.mv_valid), 32'd1);
            chk("t4_held_data", 32'(bus.mv_data), 32'(expMem[expRd[10:0]]));
            chk("t4_held_count", 32'(bus.mv_count), 32'(c0));
        end
        chk("t4_no_rden_stalled", 32'(rdenCnt - rb), 32'd0);
        waitDrain(400, 100, "t4");

        // lmg_done pulse mid-word with another word still queued
        c0 = int'(bus.mv_count);
        e0 = expWr;
        bus.mv_ready = 1'b0;
        pushWord(makeWord(100), 1'b1);
        pushWord(makeWord(70), 1'b1);
        waitValid(20, "t5");
        bus.lmg_done = 1'b1;
        tick();
        bus.lmg_done = 1'b0;
        waitDrain(400, 60, "t5");
        waitAllDone(20, "t5");
        chk("t5_mv_count", 32'(bus.mv_count), 32'(c0 + expWr - e0));
        doReset();

        // Reset while holding a move; unpacking restarts from the next FIFO word
        wa = makeWord(100);
        wb = makeWord(70);
        pushWord(wa, 1'b1);
        pushWord(wb, 1'b0);
        waitValid(20, "t6");
        expStart = expWr;
        reset = 1'b1;
        tick();
        chk("t6_rst_mv_valid", 32'(bus.mv_valid), 32'd0);
        chk("t6_rst_mv_count", 32'(bus.mv_count), 32'd0);
        chk("t6_rst_all_done", 32'(bus.all_done), 32'd0);
        chk("t6_rst_rden", 32'(bus.rden), 32'd0);
        reset = 1'b0;
        e0 = expWr;
        addExp(wb);
        waitDrain(400, 80, "t6");
        chk("t6_mv_count", 32'(bus.mv_count), 32'(expWr - e0));
        bus.lmg_done = 1'b1;
        waitAllDone(20, "t6");
        doReset();

        // Random density and backpressure, then enough full words to saturate the counter
        e0 = expWr;
        for (int i = 0; i < 40; i++) begin
            pushWord(makeWord(int'($urandom_range(100))), 1'b1);
            repeat ($urandom_range(12)) begin
                bus.mv_ready = (int'($urandom_range(99)) < 70);
                tick();
            end
        end
        for (int i = 0; i < 64; i++) begin
            pushWord(makeWord(100), 1'b1);
            repeat ($urandom_range(3)) begin
                bus.mv_ready = (int'($urandom_range(99)) < 80);
                tick();
            end
        end
        waitDrain(20000, 75, "t7");
        tot = expWr - e0;
        chk("t7_mv_count_sat", 32'(bus.mv_count), 32'((tot > 511) ? 511 : tot));
        bus.lmg_done = 1'b1;
        waitAllDone(40, "t7");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
